// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared cpu types and width defaults for fetch, ROM and decode
package instr_fetch_pkg;

    localparam int ADDR_WIDTH_DEF  = 11;
    localparam int INSTR_WIDTH_DEF = 9;

    localparam logic [INSTR_WIDTH_DEF-1:0] HALT_INSTR_DEF = {INSTR_WIDTH_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, ROM addressing, fetch/decode register, branch squash, halt
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                      ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int                      INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0]   START_ADDR  = '0,
    parameter logic [INSTR_WIDTH-1:0]  HALT_INSTR  = {INSTR_WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic [ADDR_WIDTH-1:0]  instr_addr,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid,
    output logic                   done,
    output logic [15:0]            instr_count
);

    fetch_state_t           state, state_n;
    logic [ADDR_WIDTH-1:0]  pc, pc_n;
    logic [INSTR_WIDTH-1:0] instr_out_n;
    logic [ADDR_WIDTH-1:0]  instr_pc_n;
    logic                   instr_valid_n;
    logic                   done_n;
    logic [15:0]            instr_count_n;

    // The ROM is combinational, so its address is simply the PC register.
    assign instr_addr = pc;

    // Next-state and next-output decode; every register holds unless a case below updates it.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_out_n   = instr_out;
        instr_pc_n    = instr_pc;
        instr_valid_n = instr_valid;
        done_n        = done;
        instr_count_n = instr_count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n       = RUN;
                    pc_n          = START_ADDR;
                    instr_count_n = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (branch_taken) begin
                        // The word at pc is on the wrong path; drop it and redirect.
                        pc_n          = branch_target;
                        instr_valid_n = 1'b0;
                    end else begin
                        instr_out_n   = instr_in;
                        instr_pc_n    = pc;
                        instr_valid_n = 1'b1;
                        instr_count_n = instr_count + 16'd1;
                        if (instr_in == HALT_INSTR) begin
                            state_n = HALTED;
                            done_n  = 1'b1;
                        end else begin
                            pc_n = pc + 1'b1;
                        end
                    end
                end
            end
            HALTED: begin
                // The halt word was shown for exactly one cycle on entry.
                instr_valid_n = 1'b0;
                if (start) begin
                    state_n       = RUN;
                    pc_n          = START_ADDR;
                    instr_count_n = '0;
                    done_n        = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Single register bank for state, PC and the fetch/decode register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_out   <= instr_out_n;
            instr_pc    <= instr_pc_n;
            instr_valid <= instr_valid_n;
            done        <= done_n;
            instr_count <= instr_count_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int AW = 11;
    localparam int IW = 9;
    localparam logic [IW-1:0] HALT = {IW{1'b1}};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic [AW-1:0] instr_addr;
    logic [IW-1:0] instr_in;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          done;
    logic [15:0]   instr_count;

    logic          start_w = 1'b0;
    logic [AW-1:0] addr_w;
    logic [IW-1:0] in_w;
    logic [IW-1:0] out_w;
    logic [AW-1:0] pc_w;
    logic          valid_w;
    logic          done_w;
    logic [15:0]   cnt_w;

    logic [IW-1:0] rom [2048];

    assign instr_in = rom[instr_addr];
    assign in_w     = rom[addr_w];

    always #5 clk = ~clk;

    instr_fetch u_dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_addr(instr_addr), .instr_in(instr_in), .instr_out(instr_out),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .done(done),
        .instr_count(instr_count)
    );

    instr_fetch #(.START_ADDR(11'd2046)) u_wrap (
        .clk(clk), .reset(reset), .start(start_w), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(11'd0),
        .instr_addr(addr_w), .instr_in(in_w), .instr_out(out_w),
        .instr_pc(pc_w), .instr_valid(valid_w), .done(done_w),
        .instr_count(cnt_w)
    );

    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
        logic [15:0]   cnt;
    } exp_t;

    exp_t sb [$];
    int   vectors = 0;
    int   miscompares = 0;
    logic stall_q = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [IW-1:0] instr, input logic [AW-1:0] pc, input logic [15:0] cnt);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.cnt   = cnt;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_pc(input int pc_t);
        bit found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            found = instr_valid && (instr_pc == AW'(pc_t));
        end
        check("wait_pc_timeout", found, 1);
    endtask

    task automatic wait_done();
        bit found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            found = done;
        end
        check("wait_done_timeout", found, 1);
    endtask

    // Remember whether the edge just taken was a stalled one, so a held word is not re-counted.
    always @(posedge clk) stall_q = stall;

    // Monitor: every freshly delivered valid word must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && instr_valid && !stall_q) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected: got pc %0d instr %0d expected no delivery", instr_pc, instr_out);
            end else begin
                e = sb.pop_front();
                check("sb_instr", instr_out, e.instr);
                check("sb_pc", instr_pc, e.pc);
                check("sb_count", instr_count, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wrap_pc [4];
        int wrap_in [4];
        wrap_pc = '{2046, 2047, 0, 1};
        wrap_in = '{254, 255, 0, 1};

        for (int i = 0; i < 2048; i++) rom[i] = IW'(i % 256);
        rom[4]   = HALT;
        rom[102] = HALT;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_addr", instr_addr, 0);
        check("rst_out", instr_out, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_done", done, 0);
        check("rst_count", instr_count, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_addr", instr_addr, 0);
        check("idle_valid", instr_valid, 0);

        // Straight-line program ending in HALT
        push(9'd0, 11'd0, 16'd1); push(9'd1, 11'd1, 16'd2); push(9'd2, 11'd2, 16'd3);
        push(9'd3, 11'd3, 16'd4); push(HALT, 11'd4, 16'd5);
        pulse_start();
        check("start_pc", instr_addr, 0);
        check("start_valid", instr_valid, 0);
        wait_done();
        check("halt_instr", instr_out, HALT);
        check("halt_pc", instr_pc, 4);
        check("halt_count", instr_count, 5);
        check("halt_valid", instr_valid, 1);
        @(negedge clk);
        check("post_halt_valid", instr_valid, 0);
        check("post_halt_done", done, 1);
        check("post_halt_addr", instr_addr, 4);
        check("t1_sb_empty", sb.size(), 0);

        // Taken branch at instr_pc=2 to 100: one bubble, word 3 never valid
        push(9'd0, 11'd0, 16'd1); push(9'd1, 11'd1, 16'd2); push(9'd2, 11'd2, 16'd3);
        push(9'h064, 11'd100, 16'd4); push(9'h065, 11'd101, 16'd5); push(HALT, 11'd102, 16'd6);
        pulse_start();
        wait_pc(2);
        branch_taken = 1'b1; branch_target = 11'd100;
        @(negedge clk);
        check("br_bubble", instr_valid, 0);
        check("br_addr", instr_addr, 100);
        branch_taken = 1'b0;
        wait_done();
        @(negedge clk);
        check("t2_sb_empty", sb.size(), 0);

        // Three-cycle stall mid-stream
        push(9'd0, 11'd0, 16'd1); push(9'd1, 11'd1, 16'd2); push(9'd2, 11'd2, 16'd3);
        push(9'd3, 11'd3, 16'd4); push(HALT, 11'd4, 16'd5);
        pulse_start();
        wait_pc(1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_pc", instr_pc, 1);
            check("stall_out", instr_out, 1);
            check("stall_count", instr_count, 2);
        end
        stall = 1'b0;
        wait_done();
        @(negedge clk);
        check("t3_sb_empty", sb.size(), 0);

        // Stall with branch held: redirect only once the stall drops
        push(9'd0, 11'd0, 16'd1); push(9'd1, 11'd1, 16'd2);
        push(9'h064, 11'd100, 16'd3); push(9'h065, 11'd101, 16'd4); push(HALT, 11'd102, 16'd5);
        pulse_start();
        wait_pc(1);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 11'd100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("sb_stall_pc", instr_pc, 1);
            check("sb_stall_addr", instr_addr, 2);
        end
        stall = 1'b0;
        @(negedge clk);
        check("sb_br_bubble", instr_valid, 0);
        check("sb_br_addr", instr_addr, 100);
        branch_taken = 1'b0;
        wait_done();
        @(negedge clk);
        check("t4_sb_empty", sb.size(), 0);

        // Asynchronous reset between edges
        push(9'd0, 11'd0, 16'd1); push(9'd1, 11'd1, 16'd2); push(9'd2, 11'd2, 16'd3);
        pulse_start();
        wait_pc(2);
        #2 reset = 1'b1;
        #1;
        check("arst_addr", instr_addr, 0);
        check("arst_out", instr_out, 0);
        check("arst_pc", instr_pc, 0);
        check("arst_valid", instr_valid, 0);
        check("arst_done", done, 0);
        check("arst_count", instr_count, 0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check("arst_idle_addr", instr_addr, 0);
        check("t5_sb_empty", sb.size(), 0);

        // Restart; HALT fetched on the squashed path must not halt
        push(9'd0, 11'd0, 16'd1); push(9'd1, 11'd1, 16'd2); push(9'd2, 11'd2, 16'd3);
        push(9'd3, 11'd3, 16'd4);
        push(9'h064, 11'd100, 16'd5); push(9'h065, 11'd101, 16'd6); push(HALT, 11'd102, 16'd7);
        pulse_start();
        wait_pc(3);
        branch_taken = 1'b1; branch_target = 11'd100;
        @(negedge clk);
        check("sq_valid", instr_valid, 0);
        check("sq_done", done, 0);
        check("sq_addr", instr_addr, 100);
        branch_taken = 1'b0;
        wait_done();
        @(negedge clk);
        check("t6_sb_empty", sb.size(), 0);

        // PC wrap from START_ADDR=2046
        @(negedge clk) start_w = 1'b1;
        @(negedge clk) start_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wrap_valid", valid_w, 1);
            check("wrap_pc", pc_w, wrap_pc[i]);
            check("wrap_instr", out_w, wrap_in[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage of the CPU: owns the program counter, drives the address of the combinational instruction ROM, and registers the returned word into a fetch/decode register with a valid flag. It handles start, stall, taken-branch redirect with squash, and halt detection. It sits between the top-level control and the decoder; the ROM is instantiated beside it at top level.

## Interface
- ADDR_WIDTH, 11, PC and ROM address width.
- INSTR_WIDTH, 9, instruction width.
- START_ADDR, 0, PC loaded on `start`.
- HALT_INSTR, all-ones of INSTR_WIDTH, encoding that ends execution.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution from START_ADDR.
- stall  in  1  holds the PC and the fetch register.
- branch_taken  in  1  the instruction currently in instr_out redirects fetch.
- branch_target  in  ADDR_WIDTH  redirect address.
- instr_addr  out  ADDR_WIDTH  ROM address; always equals the PC register.
- instr_in  in  INSTR_WIDTH  ROM data for instr_addr, same cycle.
- instr_out  out  INSTR_WIDTH  registered instruction to decode.
- instr_pc  out  ADDR_WIDTH  address of instr_out.
- instr_valid  out  1  instr_out is a real, non-squashed instruction.
- done  out  1  high while in HALTED.
- instr_count  out  16  count of instructions delivered with instr_valid=1; wraps.

## Operation
- States: IDLE, RUN, HALTED.
- Reset: all outputs and registers are 0, including pc, instr_out, instr_pc, instr_valid, done and instr_count. State goes to IDLE.
- IDLE:
  - start → RUN, pc←START_ADDR, instr_count←0.
  - All other inputs are ignored.
- RUN, stall=1:
  - pc, instr_out, instr_pc, instr_valid and instr_count hold.
  - branch_taken is ignored; decode must keep it asserted until the stall clears.
- RUN, stall=0, branch_taken=1:
  - pc←branch_target, instr_valid←0 (squashes the sequential word).
  - No halt check this cycle.
- RUN, stall=0, branch_taken=0:
  - instr_out←instr_in, instr_pc←pc, instr_valid←1, instr_count+1.
  - If instr_in==HALT_INSTR: → HALTED, and pc holds.
  - Otherwise pc←pc+1, modulo 2^ADDR_WIDTH (2047 wraps to 0).
- HALTED:
  - instr_valid←0 after the halt word has been presented for one cycle; done=1.
  - stall and branch_taken are ignored.
  - start → RUN from START_ADDR and clears instr_count.
- start in RUN is ignored.
- Reset asserted mid-run returns everything to the reset values immediately (asynchronous).

## Timing
- ROM read is combinational: instr_in corresponds to the current pc in the same cycle.
- Fetch latency is 1 cycle: the word at pc appears on instr_out the next edge.
- start at cycle k: state=RUN and pc=START_ADDR at k+1. The first instr_valid=1 (instr_pc=START_ADDR) is at k+2.
- Throughput is one instruction per unstalled cycle.
- Taken-branch penalty is one bubble: the target instruction is valid 2 cycles after the branch cycle.
- done rises the same edge the halt word enters instr_out.

## Structure
- Shared cpu package holds:
  - fetch_state_t enum {IDLE, RUN, HALTED}.
  - HALT_INSTR default.
  - ADDR_WIDTH/INSTR_WIDTH defaults, shared with the ROM and the decoder.
- No sub-module: a single always_ff for pc/state/fetch register, plus combinational next-pc/next-state logic.

## Test plan
- Reset then start; ROM holds 0,1,2,3,HALT at 0..4 → instr_out 0,1,2,3,HALT with instr_pc 0..4 on consecutive cycles. done=1 on the HALT cycle, instr_count=5, instr_valid=0 the cycle after.
- Branch: branch_taken=1 with target 100 while instr_pc=2 → next cycle instr_valid=0, then instr_pc=100; the word at address 3 is never valid.
- Stall for 3 cycles mid-stream → instr_out, instr_pc and instr_count frozen; stream resumes with no skipped or duplicated address.
- Stall and branch_taken together for 2 cycles, then stall drops with branch still high → redirect happens only after stall drops.
- PC wrap: start with START_ADDR=2046, no halt → instr_pc 2046, 2047, 0, 1.
- Reset asserted mid-RUN, between clock edges → all outputs 0 immediately, state IDLE. A subsequent start re-runs cleanly. A HALT fetched on a squashed path (branch in the same cycle) does not halt.
